word_assembler: RTL

//  Parametrised narrow-to-wide assembler for the Baby RAM data-input path.

---
 rtl/word_assembler.sv | 100 ++++++++++
 1 files changed

// File: rtl/word_assembler.sv
// word_assembler: collects OUT_W-bit words from serial bits or IN_W-bit chunks,
// MSB first, and delivers each finished word through a valid/ready output register.
// A sticky overrun flag records any finished word dropped because the output was full.
module word_assembler #(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned IN_W  = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    input  logic                       serialise_i,
    input  logic                       strobe_i,
    input  logic [IN_W-1:0]            value_i,
    output logic [OUT_W-1:0]           value_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       busy_o,
    output logic [$clog2(OUT_W):0]     count_o,
    output logic                       overrun_o
);

    localparam int unsigned CW        = $clog2(OUT_W) + 1;
    localparam int unsigned SER_BEATS = OUT_W;
    localparam int unsigned CHK_BEATS = OUT_W / IN_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             state_q;
    logic [OUT_W-1:0]   sr_q;
    logic [CW-1:0]      count_q;
    logic               mode_q;

    logic               eff_mode_c;
    logic [CW-1:0]      last_c;
    logic [OUT_W-1:0]   shifted_c;
    logic               done_c;

    // Mode of the current beat: sampled live on the first beat, latched afterwards.
    always_comb begin
        eff_mode_c = (state_q == IDLE) ? serialise_i : mode_q;
        last_c     = eff_mode_c ? CW'(SER_BEATS - 1) : CW'(CHK_BEATS - 1);
        shifted_c  = eff_mode_c ? OUT_W'({sr_q, value_i[0]}) : OUT_W'({sr_q, value_i});
        done_c     = strobe_i && (count_q == last_c);
    end

    // Fill FSM: beat counter, shift register and latched word mode.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            sr_q    <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= IDLE;
            sr_q    <= '0;
            count_q <= '0;
        end else if (strobe_i) begin
            if (state_q == IDLE) begin
                mode_q <= serialise_i;
            end
            if (done_c) begin
                state_q <= IDLE;
                sr_q    <= '0;
                count_q <= '0;
            end else begin
                state_q <= FILL;
                sr_q    <= shifted_c;
                count_q <= count_q + CW'(1);
            end
        end
    end

    // Output register with valid/ready handoff and sticky overrun.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            value_o   <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else if (clear_i) begin
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else if (done_c) begin
            if (!valid_o || ready_i) begin
                value_o <= shifted_c;
                valid_o <= 1'b1;
            end else begin
                overrun_o <= 1'b1;
            end
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

    assign count_o = count_q;
    assign busy_o  = (state_q == FILL);

endmodule
